// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host receiver: synchronised, glitch-filtered clock, frame checker and show-ahead FIFO.
// Define PS2_RX_TIMEOUT_EN to build the intra-frame idle timeout (TIMEOUT_CYC) and the tmo_o flag.
module ps2_kbd_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 24000
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_dat_i,
    input  logic                          rx_pop_i,
    input  logic                          err_clr_i,
    output logic [7:0]                    rx_dat_o,
    output logic                          rx_vld_o,
    output logic [$clog2(FIFO_DEPTH):0]   rx_cnt_o,
    output logic                          perr_o,
    output logic                          ferr_o,
    output logic                          ovf_o,
    output logic                          tmo_o,
    output logic                          irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILT_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

    logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          filt_lvl_q, filt_lvl_d;
    logic          fe, dat_s;
    state_t        state_q, state_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic          good, perr_set, ferr_set, ovf_set;
    logic          perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop, full;
    logic [7:0]    mem_q [FIFO_DEPTH];

    assign dat_s = dat_sync_q[1];

    // Clock filter: level flips only after FILT_LEN consecutive disagreeing samples.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk_i};
        dat_sync_d = {dat_sync_q[0], ps2_dat_i};
        filt_cnt_d = '0;
        filt_lvl_d = filt_lvl_q;
        fe         = 1'b0;
        if (clk_sync_q[1] != filt_lvl_q) begin
            if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
                filt_lvl_d = ~filt_lvl_q;
                fe         = filt_lvl_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_set, tmo_q, tmo_d;
`endif

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        good      = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;
        if (fe) begin
            unique case (state_q)
                S_IDLE: if (!dat_s) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
                S_DATA: begin
                    shreg_d   = {dat_s, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = S_PAR;
                end
                S_PAR: begin
                    par_d   = dat_s;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (!dat_s)                ferr_set = 1'b1;
                    else if (!(^{shreg_q, par_q})) perr_set = 1'b1;
                    else                       good     = 1'b1;
                end
            endcase
        end
`ifdef PS2_RX_TIMEOUT_EN
        tmo_cnt_d = '0;
        tmo_set   = 1'b0;
        if (state_q != S_IDLE && !fe) begin
            if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d   = S_IDLE;
                bit_idx_d = '0;
                tmo_set   = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
        tmo_d = (tmo_q & ~err_clr_i) | tmo_set;
`endif
    end

    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    always_comb begin
        pop      = rx_pop_i & (cnt_q != '0);
        full     = (cnt_q == CW'(FIFO_DEPTH));
        push     = good & (~full | pop);
        ovf_set  = good & full & ~pop;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
        perr_d = (perr_q & ~err_clr_i) | perr_set;
        ferr_d = (ferr_q & ~err_clr_i) | ferr_set;
        ovf_d  = (ovf_q  & ~err_clr_i) | ovf_set;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_cnt_q <= '0;
            filt_lvl_q <= 1'b1;
            state_q    <= S_IDLE;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_cnt_q <= filt_cnt_d;
            filt_lvl_q <= filt_lvl_d;
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end
    assign tmo_o = tmo_q;
`else
    assign tmo_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= shreg_q;
    end

    // Head is forced to zero while empty so the reset value is defined without clearing storage.
    assign rx_vld_o = (cnt_q != '0);
    assign rx_dat_o = rx_vld_o ? mem_q[rd_ptr_q] : 8'h00;
    assign rx_cnt_o = cnt_q;
    assign perr_o   = perr_q;
    assign ferr_o   = ferr_q;
    assign ovf_o    = ovf_q;
    assign irq_o    = rx_vld_o | perr_q | ferr_q | ovf_q | tmo_o;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed + randomized bench for ps2_kbd_rx: keyboard pin model, queue-based reference model.
module tb_ps2_kbd_rx;
    localparam int DEPTH = 8;
`ifdef PS2_RX_TIMEOUT_EN
    localparam int TMO = 200;
`else
    localparam int TMO = 24000;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1, rx_pop = 1'b0, err_clr = 1'b0;
    logic [7:0] rx_dat;
    logic       rx_vld, perr, ferr, ovf, tmo, irq;
    logic [3:0] rx_cnt;

    ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .FILT_LEN(4), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
        .rx_pop_i(rx_pop), .err_clr_i(err_clr), .rx_dat_o(rx_dat), .rx_vld_o(rx_vld),
        .rx_cnt_o(rx_cnt), .perr_o(perr), .ferr_o(ferr), .ovf_o(ovf), .tmo_o(tmo), .irq_o(irq)
    );

    int errors = 0, checks = 0;
    byte unsigned q[$];
    bit e_perr, e_ferr, e_ovf, e_tmo;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(string tag);
        chk({tag, ".vld"}, 32'(rx_vld), 32'(q.size() != 0));
        chk({tag, ".cnt"}, 32'(rx_cnt), 32'(q.size()));
        if (q.size() != 0) chk({tag, ".dat"}, 32'(rx_dat), 32'(q[0]));
        chk({tag, ".perr"}, 32'(perr), 32'(e_perr));
        chk({tag, ".ferr"}, 32'(ferr), 32'(e_ferr));
        chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
        chk({tag, ".tmo"}, 32'(tmo), 32'(e_tmo));
        chk({tag, ".irq"}, 32'(irq), 32'((q.size() != 0) | e_perr | e_ferr | e_ovf | e_tmo));
    endtask

    // One PS/2 bit: data set mid-high, 20-cycle low phase, 20-cycle high phase.
    task automatic ps2_bit(bit b, bit glitch, bit pop_now);
        @(negedge clk); ps2_dat = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop_now) begin
            // Aligns the pop with the cycle the stop-bit edge pushes (2 sync + FILT_LEN).
            repeat (5) @(posedge clk);
            @(negedge clk); rx_pop = 1'b1;
            @(negedge clk); rx_pop = 1'b0;
            repeat (14) @(negedge clk);
        end else begin
            repeat (20) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        if (glitch) begin
            ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic model_frame(byte unsigned d, bit par_ok, bit stop_ok, bit popped);
        if (popped && q.size() != 0) void'(q.pop_front());
        if (!stop_ok)              e_ferr = 1'b1;
        else if (!par_ok)          e_perr = 1'b1;
        else if (q.size() < DEPTH) q.push_back(d);
        else                       e_ovf = 1'b1;
    endtask

    task automatic send_frame(byte unsigned d, bit par_ok, bit stop_ok, bit glitch, bit pop_on_stop);
        bit [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        bits[9]   = par_ok ? ~(^d) : ^d;
        bits[10]  = stop_ok;
        for (int i = 0; i < 11; i++) ps2_bit(bits[i], glitch, pop_on_stop && i == 10);
        model_frame(d, par_ok, stop_ok, pop_on_stop);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_pop(string tag);
        @(negedge clk); rx_pop = 1'b1;
        @(negedge clk); rx_pop = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        check_state(tag);
    endtask

    task automatic do_clr(string tag);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        e_perr = 0; e_ferr = 0; e_ovf = 0; e_tmo = 0;
        check_state(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_state("reset");
        chk("reset.dat", 32'(rx_dat), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_state("idle");

        send_frame(8'h41, 1, 1, 0, 0);
        check_state("good41");
        do_pop("pop41");

        send_frame(8'h41, 0, 1, 0, 0);
        check_state("perr41");
        do_clr("clr_perr");

        send_frame(8'h41, 1, 0, 0, 0);
        check_state("ferr41");
        send_frame(8'h41, 0, 0, 0, 0);
        check_state("both_err");
        do_clr("clr_ferr");

        for (int i = 0; i < 9; i++) send_frame(byte'(8'h41 + i), 1, 1, 0, 0);
        check_state("fill9");
        chk("fill9.cnt8", 32'(rx_cnt), 32'd8);
        chk("fill9.ovf", 32'(ovf), 32'd1);
        send_frame(8'h4A, 1, 1, 0, 1);
        check_state("full_pop_push");
        chk("full_pop_push.cnt8", 32'(rx_cnt), 32'd8);
        for (int i = 0; i < 8; i++) do_pop("drain");
        do_clr("clr_ovf");

        send_frame(8'h5A, 1, 1, 1, 0);
        check_state("glitch5A");
        do_pop("pop5A");

        ps2_bit(1'b0, 0, 0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 0, 0);
        @(negedge clk); rst_n = 1'b0; ps2_dat = 1'b1; ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
        q.delete(); e_perr = 0; e_ferr = 0; e_ovf = 0; e_tmo = 0;
        check_state("midreset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h1C, 1, 1, 0, 0);
        check_state("after_reset1C");
        do_pop("pop1C");

        for (int n = 0; n < 8; n++) begin
            byte unsigned d;
            int kind;
            d    = byte'($urandom);
            kind = $urandom_range(0, 3);
            send_frame(d, kind != 2, kind != 3, 0, 0);
            check_state("rand");
            if ($urandom_range(0, 1) == 1) do_pop("rand_pop");
            if (kind >= 2 && $urandom_range(0, 1) == 1) do_clr("rand_clr");
        end
        while (q.size() != 0) do_pop("rand_drain");
        do_clr("rand_final_clr");

`ifdef PS2_RX_TIMEOUT_EN
        begin
            int n;
            ps2_bit(1'b0, 0, 0);
            ps2_bit(1'b1, 0, 0);
            ps2_bit(1'b0, 0, 0);
            ps2_bit(1'b1, 0, 0);
            // Last edge was seen about 34 cycles before this point.
            n = 0;
            while (!tmo && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("tmo.set", 32'(tmo), 32'd1);
            chk("tmo.late", 32'((34 + n) <= 202), 32'd1);
            chk("tmo.early", 32'((34 + n) >= 190), 32'd1);
            e_tmo = 1'b1;
            check_state("tmo");
            send_frame(8'h29, 1, 1, 0, 0);
            check_state("after_tmo29");
            do_pop("pop29");
            do_clr("clr_tmo");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
